// File: rtl/pipe_pkg.sv
// Shared types and per-stage default widths for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // IF/ID: ctrl = valid-instr marker, data = pc4 32 + inst 32
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  // ID/EX: ctrl = wreg m2reg wmem aluimm shift jal, data = da 32 + db 32 + imm 32 + rn 5
  localparam int IDEX_CTRL_W  = 6;
  localparam int IDEX_DATA_W  = 101;
  // EX/MEM: ctrl = wreg m2reg wmem, data = alu 32 + b 32 + rn 5
  localparam int EXMEM_CTRL_W = 3;
  localparam int EXMEM_DATA_W = 69;
  // MEM/WB: ctrl = wreg m2reg, data = mem 32 + alu 32 + rn 5
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  localparam int STALL_W_DEF  = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = STALL_W_DEF
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count register: clear, saturating increment, else hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 3,
  parameter int DATA_W  = 69,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               stall_clr
);

  state_t             state_r, state_s;
  logic               main_valid_r, main_valid_s;
  logic [CTRL_W-1:0]  main_ctrl_r, main_ctrl_s;
  logic [DATA_W-1:0]  main_data_r, main_data_s;
  logic               skid_valid_r, skid_valid_s;
  logic [CTRL_W-1:0]  skid_ctrl_r, skid_ctrl_s;
  logic [DATA_W-1:0]  skid_data_r, skid_data_s;
  logic               in_ready_r;
  logic               accept_s, send_s, stall_s;

  assign accept_s = in_valid & in_ready_r;
  assign send_s   = main_valid_r & out_ready;
  assign stall_s  = main_valid_r & ~out_ready;

  // next-state and datapath selection; flush drops every entry to a bubble
  always_comb begin
    state_s      = state_r;
    main_valid_s = main_valid_r;
    main_ctrl_s  = main_ctrl_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      state_s      = EMPTY;
      main_valid_s = 1'b0;
      main_ctrl_s  = {CTRL_W{1'b0}};
      skid_valid_s = 1'b0;
      skid_ctrl_s  = {CTRL_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_s      = ONE;
            main_valid_s = 1'b1;
            main_ctrl_s  = in_ctrl;
            main_data_s  = in_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && send_s) begin
            state_s     = ONE;
            main_ctrl_s = in_ctrl;
            main_data_s = in_data;
          end else if (accept_s) begin
            state_s      = TWO;
            skid_valid_s = 1'b1;
            skid_ctrl_s  = in_ctrl;
            skid_data_s  = in_data;
          end else if (send_s) begin
            state_s      = EMPTY;
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
          end else begin
            state_s = ONE;
          end
        end
        TWO: begin
          if (send_s) begin
            state_s      = ONE;
            main_ctrl_s  = skid_ctrl_r;
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
            skid_ctrl_s  = {CTRL_W{1'b0}};
          end else begin
            state_s = TWO;
          end
        end
        default: begin
          state_s      = EMPTY;
          main_valid_s = 1'b0;
          main_ctrl_s  = {CTRL_W{1'b0}};
          skid_valid_s = 1'b0;
          skid_ctrl_s  = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // state, entry and ready registers; in_ready is precomputed from next state
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r      <= EMPTY;
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      main_valid_r <= main_valid_s;
      main_ctrl_r  <= main_ctrl_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= (state_s != TWO);
    end
  end

  pipe_sat_cnt #(.W(STALL_W)) u_stall_cnt (
    .clk  (clk),
    .clrn (clrn),
    .clr  (stall_clr),
    .inc  (stall_s),
    .cnt  (stall_cnt)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  // gate on valid so a bubble can never present a write enable downstream
  assign out_ctrl  = main_valid_r ? main_ctrl_r : {CTRL_W{1'b0}};
  assign out_data  = main_data_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-level reference model plus directed scenarios.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [15:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [15:0] out_data;
  logic [3:0]  stall_cnt;
  logic        stall_clr;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(16), .STALL_W(4)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats, ready when not full.
  logic [2:0]  m_ctrl[$];
  logic [15:0] m_data[$];
  logic        m_ready = 1'b1;
  int          m_cnt   = 0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_ctrl.delete();
      m_data.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
    end else begin
      automatic bit acc  = in_valid && m_ready;
      automatic bit snd  = (m_data.size() > 0) && out_ready;
      automatic bit stl  = (m_data.size() > 0) && !out_ready;
      if (stall_clr) m_cnt = 0;
      else if (stl && m_cnt < 15) m_cnt = m_cnt + 1;
      if (flush) begin
        m_ctrl.delete();
        m_data.delete();
      end else begin
        if (snd) begin
          void'(m_ctrl.pop_front());
          void'(m_data.pop_front());
        end
        if (acc) begin
          m_ctrl.push_back(in_ctrl);
          m_data.push_back(in_data);
        end
      end
      m_ready = (m_data.size() < 2);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (clrn) begin
      check("out_valid", 64'(out_valid), 64'(m_data.size() > 0));
      check("in_ready", 64'(in_ready), 64'(m_ready));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (m_data.size() > 0) begin
        check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl[0]));
        check("out_data", 64'(out_data), 64'(m_data[0]));
      end else begin
        check("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
      end
    end
  end

  // Record delivered beats independently of the model
  logic [2:0]  got_ctrl[$];
  logic [15:0] got_data[$];
  bit          seen_111 = 1'b0;

  always @(negedge clk) begin
    if (clrn && out_valid && out_ready) begin
      got_ctrl.push_back(out_ctrl);
      got_data.push_back(out_data);
    end
    if (out_ctrl == 3'b111) seen_111 = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_got(input string name, input logic [15:0] base, input int n,
                            input logic [2:0] ctrl);
    check({name, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({name, "_data"}, 64'(got_data[i]), 64'(base + 16'(i)));
      check({name, "_ctrl"}, 64'(got_ctrl[i]), 64'(ctrl));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int c;
    bit acc;
    clrn = 1'b0; in_valid = 1'b0; in_ctrl = 3'd0; in_data = 16'd0;
    flush = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    // streaming, one beat per cycle, latency one
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 3'b101; in_data = 16'(i);
      cyc();
      check("stream_lat", 64'(out_data), 64'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    expect_got("stream", 16'h0001, 8, 3'b101);
    check("stream_stall", 64'(stall_cnt), 64'd0);
    got_ctrl.delete(); got_data.delete();

    // backpressure for three cycles mid-stream
    idx = 0; c = 0;
    while (idx < 8 && c < 40) begin
      in_valid = 1'b1; in_ctrl = 3'b101; in_data = 16'h0010 + 16'(idx);
      out_ready = !(c >= 2 && c <= 4);
      acc = in_ready;
      cyc();
      if (acc) idx++;
      if (c == 2) check("bp_in_ready_low", 64'(in_ready), 64'd0);
      c++;
    end
    check("bp_budget", 64'(idx), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    expect_got("bp", 16'h0010, 8, 3'b101);
    check("bp_stall", 64'(stall_cnt), 64'd3);
    got_ctrl.delete(); got_data.delete();

    // flush in TWO with a concurrent accept attempt
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b011; in_data = 16'h0021;
    cyc();
    in_data = 16'h0022;
    cyc();
    check("two_in_ready", 64'(in_ready), 64'd0);
    in_data = 16'h0023; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 64'(out_valid), 64'd0);
    check("flush2_out_ctrl", 64'(out_ctrl), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("flush2_none", 64'(got_data.size()), 64'd0);
    check("flush2_stall", 64'(stall_cnt), 64'd5);

    // flush in ONE while a ctrl 3'b111 beat is offered
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b101; in_data = 16'h0031;
    cyc();
    in_ctrl = 3'b111; in_data = 16'h0032; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("flush1_none", 64'(got_data.size()), 64'd0);
    check("flush1_no_111", 64'(seen_111), 64'd0);
    check("flush1_stall", 64'(stall_cnt), 64'd6);

    // stall counter saturation and clear
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    check("clr_idle", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b001; in_data = 16'h0041;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("sat_stall", 64'(stall_cnt), 64'd15);
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    check("clr_in_stall", 64'(stall_cnt), 64'd0);

    // async reset pulse while in TWO
    in_valid = 1'b1; in_data = 16'h0042;
    cyc();
    in_valid = 1'b0;
    check("pre_rst_two", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    got_ctrl.delete(); got_data.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 3'b110; in_data = 16'h0051;
    cyc();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data", 64'(out_data), 64'h51);
    check("post_rst_ctrl", 64'(out_ctrl), 64'd6);
    repeat (2) cyc();
    expect_got("post_rst", 16'h0051, 1, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU, the successor to the fixed EX/MEM latch. It carries a control field and a data payload between two stages with a valid/ready handshake, a two-entry skid buffer (registered `in_ready`), synchronous flush that turns in-flight instructions into bubbles, and a saturating stall counter. One instance replaces each of IF/ID, ID/EX, EX/MEM and MEM/WB by parameter choice.

## Interface
Parameters:
- `CTRL_W`, 3: control bits (e.g. wreg, m2reg, wmem); forced to zero on bubbles.
- `DATA_W`, 69: payload bits (e.g. alu 32 + b 32 + rn 5).
- `STALL_W`, 16: stall counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `clrn`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage accepts a beat this cycle; registered.
- `in_ctrl`  in  CTRL_W  upstream control.
- `in_data`  in  DATA_W  upstream payload.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control; all-zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  payload.
- `stall_cnt`  out  STALL_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.
- `stall_clr`  in  1  synchronous clear of `stall_cnt`.

## Operation
- Storage: main entry (drives outputs) and skid entry, each holding valid, ctrl and data.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid).
- Accept = `in_valid && in_ready`; send = `out_valid && out_ready`.
- EMPTY: accept -> ONE, beat into main.
- ONE: accept and send -> ONE, beat into main. Accept only -> TWO, beat into skid. Send only -> EMPTY.
- TWO: `in_ready`=0. Send -> ONE, skid moves to main. No send -> hold.
- Order preserved; no beat is duplicated or dropped except by flush.
- `flush`=1: next state EMPTY, both valids cleared, both ctrl fields zeroed. A beat accepted in the same cycle is discarded. Flush overrides every other event. Data fields hold their previous value.
- `out_ctrl` = main ctrl gated by main valid, so a bubble can never assert a write enable.
- `stall_cnt` increments once per cycle with `out_valid && !out_ready` and saturates at all-ones.
  - `stall_clr` forces it to 0 and wins over an increment in the same cycle.
  - `stall_cnt` is unaffected by `flush`.

## Timing
- Reset (`clrn`=0, asynchronous): state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid contents 0, `stall_cnt`=0, `in_ready`=1.
- Reset may assert mid-transfer. All held beats are lost. The first accept after release is on the first rising edge with `clrn`=1.
- Latency: a beat accepted at edge N is on `out_*` after edge N, i.e. it is visible during cycle N+1.
- Throughput: one beat per cycle while `out_ready` stays high.
- `in_ready` is a flop. It is 0 exactly in state TWO, and after a flush it is 1 in the next cycle.
- `in_ready` has no combinational path from `out_ready`; the outputs have no combinational path from any `in_*` input.
- Upstream must hold `in_ctrl`/`in_data` stable while `in_valid`=1 and `in_ready`=0.

## Structure
- Shared package `pipe_pkg`:
  - state enum {EMPTY, ONE, TWO};
  - default widths for the per-stage instances (IF/ID, ID/EX, EX/MEM, MEM/WB CTRL_W/DATA_W constants).
- One sub-module is natural: `pipe_sat_cnt` (STALL_W saturating counter with clear and increment). Everything else stays inline.

## Test plan
- Reset then streaming: `out_ready`=1, feed ctrl 3'b101 with data 0x1..0x8 on consecutive cycles. Expected: same sequence out, each one cycle later; `in_ready` stays 1; `stall_cnt`=0.
- Backpressure: drop `out_ready` for 3 cycles mid-stream while `in_valid`=1.
  - Expected: `in_ready` falls after the second held beat and state reaches TWO.
  - Expected: no loss or reorder after release; `stall_cnt`=3.
- Flush in TWO with a concurrent accept attempt. Expected: next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and the flushed beats never appear.
- Flush in ONE while `in_valid`=1 with ctrl 3'b111. Expected: the beat is discarded and `out_ctrl` never shows 3'b111.
- Saturation: STALL_W=4, hold `out_valid`=1 with `out_ready`=0 for 20 cycles. Expected: `stall_cnt`=15. Then assert `stall_clr` in a stall cycle; expected: `stall_cnt`=0.
- Async reset pulse in TWO, asserted between clock edges. Expected: outputs zero immediately without waiting for an edge, `in_ready`=1; after release, the first beat returns with latency 1.
